argmax_fp32: RTL

Streaming arg-max stage for the next-word predictor's output layer. Accepts one IEEE-754 single-precision logit per beat over a valid/ready handshake, for `VOCAB_SIZE` beats per scan. Tracks the running maximum and its index, then presents the winning token index and score until the next scan starts. Sits downstream of the fp32 logit producer and replaces a tree of combinational comparators with one registered comparison per cycle.

---
 rtl/argmax_fp32.sv | 129 ++++++++++++
 1 files changed

// File: rtl/argmax_fp32.sv
// argmax_fp32: streaming arg-max over VOCAB_SIZE fp32 logits per scan.
// Keeps one running best (score + index) and does a single registered
// comparison per accepted beat. The result is held in DONE until the next start.
// Optional build macro ARGMAX_NAN_SKIP_EN: when it is defined, NaN beats are
// counted but never compete. A scan made up only of NaNs then reports the
// canonical quiet NaN at index 0.

module argmax_fp32 #(
    parameter int VOCAB_SIZE = 1024,
    parameter int IDX_W      = $clog2(VOCAB_SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [31:0]      out_score,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOCAB_SIZE - 1);

    // Maps an fp32 pattern onto an unsigned key whose integer order matches
    // the numeric order. -0 is folded onto +0 so that the two compare equal.
    function automatic logic [31:0] order_key(input logic [31:0] bits);
        logic [31:0] b;
        b = (bits == 32'h8000_0000) ? 32'h0000_0000 : bits;
        return b[31] ? ~b : {1'b1, b[30:0]};
    endfunction

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] best_idx;
    logic [31:0]      best_score;
    logic             have_best;

    logic accept;
    logic last_beat;
    logic candidate;
    logic beat_wins;
    logic load_beat;

    // A start pulse during SCAN throws away the beat offered in that same cycle.
    assign accept    = (state == SCAN) && in_valid && !start;
    assign last_beat = (count == LAST_IDX);

`ifdef ARGMAX_NAN_SKIP_EN
    assign candidate = !((in_data[30:23] == 8'hFF) && (in_data[22:0] != 23'd0));
`else
    assign candidate = 1'b1;
`endif

    assign beat_wins = order_key(in_data) > order_key(best_score);
    assign load_beat = accept && candidate && (!have_best || beat_wins);

    // The next state: start always (re)enters SCAN; the final accepted beat ends the scan.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = SCAN;
            SCAN: begin
                if (start) begin
                    state_next = SCAN;
                end else if (accept && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: if (start) state_next = SCAN;
            default: state_next = IDLE;
        endcase
    end

    // The state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The beat counter and the have_best flag. Both clear on every start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            have_best <= 1'b0;
        end else if (start) begin
            count     <= '0;
            have_best <= 1'b0;
        end else if (accept) begin
            count <= last_beat ? '0 : count + IDX_W'(1);
            if (load_beat) begin
                have_best <= 1'b1;
            end
        end
    end

    // The running best. The first candidate loads unconditionally; later candidates replace it only when strictly greater.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_score <= 32'h0000_0000;
            best_idx   <= '0;
        end else if (load_beat) begin
            best_score <= in_data;
            best_idx   <= count;
        end
`ifdef ARGMAX_NAN_SKIP_EN
        else if (accept && last_beat && !have_best) begin
            best_score <= 32'h7FC0_0000;
            best_idx   <= '0;
        end
`endif
    end

    assign in_ready  = (state == SCAN);
    assign busy      = (state == SCAN);
    assign out_valid = (state == DONE);
    assign out_index = best_idx;
    assign out_score = best_score;

endmodule
